spi_sclk_gen: RTL and testbench
===============================

# spi_sclk_gen

Parametrised SPI master serial-clock and bit-strobe generator, the successor to the fixed 3-bit-prescaler baud-rate generator. It runs one complete SPI transfer of a programmable length in any of the four CPOL/CPHA modes. It produces SCLK plus single-cycle shift and sample strobes aligned to SCLK edges, and a start/busy/done handshake to the SPI control FSM. Configuration is frozen at start, so APB writes during a transfer cannot glitch SCLK.

## Interface
- SPR_W, 3: width of spr_i; divisor exponent range 0..2^SPR_W-1.
- SPPR_W, 3: width of sppr_i; divisor pre-multiplier range 0..2^SPPR_W-1.
- LEN_W, 5: width of len_i; transfer length N = len_i+1 bits (1..2^LEN_W).
- Derived: DIV_W = SPPR_W + 2^SPR_W + 1, the half-period counter width (12 at defaults).
- clk_i  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  request a transfer; only sampled while idle.
- abort_i  in  1  terminate the current transfer immediately.
- cpol_i  in  1  clock idle level.
- cpha_i  in  1  clock phase.
- spr_i  in  SPR_W  divisor exponent.
- sppr_i  in  SPPR_W  divisor pre-multiplier.
- len_i  in  LEN_W  bits per transfer minus one.
- sclk_o  out  1  serial clock, registered.
- shift_o  out  1  one-cycle pulse: launch next TX bit.
- sample_o  out  1  one-cycle pulse: capture RX bit.
- last_o  out  1  qualifies the final sample_o pulse of the transfer.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle pulse at normal completion.

## Operation
- Half period: H = (sppr+1) << (spr+1) clk_i cycles, computed at DIV_W bits with no overflow. Minimum H = 2 (SCLK = clk/4); maximum is 2048 at defaults.
- States: IDLE, RUN, TRAIL.
- IDLE:
  - sclk_o <= cpol_i every cycle.
  - All strobes and busy_o are 0.
  - If start_i=1 and abort_i=0: latch cpol, cpha, spr, sppr, len; clear the half-period counter and edge counter; go to RUN.
- RUN:
  - The counter counts 0..H-1 and wraps.
  - On each wrap, sclk_o toggles and edge index e (1..2N) increments. The edge counter is LEN_W+2 bits wide.
  - Odd e is a leading edge; even e is a trailing edge.
  - When e = 2N, go to TRAIL with the counter cleared.
- Strobe rules:
  - CPHA=0: sample_o on odd e (1..2N-1). shift_o on even e from 2 to 2N-2; the first bit is preloaded by the controller at start.
  - CPHA=1: shift_o on odd e (1..2N-1). sample_o on even e (2..2N).
  - last_o is high only together with the Nth sample_o.
- TRAIL:
  - sclk_o holds the latched cpol for H cycles; this is the SS hold time.
  - Then done_o=1 for one cycle, busy_o=0, go to IDLE.
- busy_o = 1 in RUN and TRAIL.
- start_i while busy is ignored.
- Input config changes while busy have no effect.
- abort_i=1 in RUN or TRAIL:
  - Next cycle: IDLE, sclk_o = latched cpol, all strobes 0, no done_o.
  - abort_i has priority over start_i and over a simultaneous counter wrap.
- Reset values: sclk_o=0, shift_o=0, sample_o=0, last_o=0, busy_o=0, done_o=0, state IDLE, counters 0.
- sclk_o reaches cpol_i one cycle after reset release.
- Asserting reset mid-transfer returns the block to these values immediately.

## Timing
- Let t0 be the clk_i edge at which start is accepted.
- busy_o is high from t0+1.
- Edge e: sclk_o toggles and the corresponding strobe is visible in the same cycle, after clock edge t0 + e·H. All outputs are driven from the same flop edge.
- done_o is high and busy_o low after t0 + (2N+1)·H.
- Back-to-back: start_i held high during the done_o cycle is accepted at the next edge (one idle cycle minimum).
- Strobes never assert in two consecutive cycles, since H ≥ 2.

## Test plan
- Mode 0, spr=0, sppr=0, len=7 (H=2, N=8) -> rising edges at t0+2,6,…,30; sample_o at those 8 points; shift_o at t0+4,8,…,28 (7 pulses); last_o at t0+30; done_o at t0+34.
- Mode 3 (cpol=1, cpha=1), spr=1, sppr=2 (H=12), len=3 -> idle sclk_o=1; shift_o on falling edges at t0+12,36,60,84; sample_o on rising edges at t0+24,…,96; done_o at t0+108.
- Maximum divisor, spr=7, sppr=7, len=0 -> H=2048; edges at t0+2048 and t0+4096; done_o at t0+6144; no counter overflow.
- Change cpol_i, spr_i, and len_i and pulse start_i mid-transfer -> waveform is identical to the undisturbed run; no second transfer starts.
- abort_i at t0+7 in mode 1 -> sclk_o=0 and busy_o=0 at t0+8; no further strobes; no done_o; a new start is accepted at the next cycle.
- rst_n asserted mid-RUN, then released -> all outputs 0 asynchronously; sclk_o equals cpol_i one cycle after release; a normal transfer then completes.

Source files
------------

// File: rtl/spi_sclk_gen.sv
// SPI master SCLK and shift/sample strobe generator with programmable divisor,
// transfer length and CPOL/CPHA mode; configuration is frozen at start.
module spi_sclk_gen #(
  parameter int SPR_W  = 3,
  parameter int SPPR_W = 3,
  parameter int LEN_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic [SPR_W-1:0]  spr_i,
  input  logic [SPPR_W-1:0] sppr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              sclk_o,
  output logic              shift_o,
  output logic              sample_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int DIV_W  = SPPR_W + (1 << SPR_W) + 1;
  localparam int EDGE_W = LEN_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    TRAIL
  } state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    cnt_q;
  logic [EDGE_W-1:0]   edge_cnt_q;
  logic                cpol_q;
  logic                cpha_q;
  logic [SPR_W-1:0]    spr_q;
  logic [SPPR_W-1:0]   sppr_q;
  logic [LEN_W-1:0]    len_q;

  logic [SPR_W:0]      shamt;
  logic [DIV_W-1:0]    half_per;
  logic [EDGE_W-1:0]   edge_nx;
  logic [EDGE_W-1:0]   two_n;
  logic                wrap;
  logic                odd;

  // The shift amount is one bit wider than spr so spr+1 cannot wrap to zero.
  assign shamt    = {1'b0, spr_q} + {{SPR_W{1'b0}}, 1'b1};
  assign half_per = (DIV_W'(sppr_q) + DIV_W'(1)) << shamt;
  assign wrap     = (cnt_q == (half_per - DIV_W'(1)));
  assign edge_nx  = edge_cnt_q + EDGE_W'(1);
  assign two_n    = (EDGE_W'(len_q) + EDGE_W'(1)) << 1;
  assign odd      = edge_nx[0];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      spr_q      <= '0;
      sppr_q     <= '0;
      len_q      <= '0;
      sclk_o     <= 1'b0;
      shift_o    <= 1'b0;
      sample_o   <= 1'b0;
      last_o     <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      shift_o  <= 1'b0;
      sample_o <= 1'b0;
      last_o   <= 1'b0;
      done_o   <= 1'b0;
      case (state_q)
        IDLE: begin
          sclk_o <= cpol_i;
          busy_o <= 1'b0;
          if (start_i && !abort_i) begin
            cpol_q     <= cpol_i;
            cpha_q     <= cpha_i;
            spr_q      <= spr_i;
            sppr_q     <= sppr_i;
            len_q      <= len_i;
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            busy_o     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (abort_i) begin
            sclk_o     <= cpol_q;
            busy_o     <= 1'b0;
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            state_q    <= IDLE;
          end else if (wrap) begin
            cnt_q      <= '0;
            sclk_o     <= ~sclk_o;
            edge_cnt_q <= edge_nx;
            // CPHA=0 preloads the first bit, so no shift on the final trailing edge.
            if (!cpha_q) begin
              sample_o <= odd;
              shift_o  <= !odd && (edge_nx != two_n);
              last_o   <= odd && (edge_nx == (two_n - EDGE_W'(1)));
            end else begin
              shift_o  <= odd;
              sample_o <= !odd;
              last_o   <= (edge_nx == two_n);
            end
            if (edge_nx == two_n) begin
              state_q <= TRAIL;
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        TRAIL: begin
          if (abort_i) begin
            sclk_o     <= cpol_q;
            busy_o     <= 1'b0;
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            state_q    <= IDLE;
          end else if (wrap) begin
            done_o     <= 1'b1;
            busy_o     <= 1'b0;
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: traces each transfer cycle by cycle and
// compares it against the edge/strobe timing expected for the configured mode.
module tb_spi_sclk_gen;

  logic       clk_i   = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       cpol_i  = 1'b0;
  logic       cpha_i  = 1'b0;
  logic [2:0] spr_i   = 3'd0;
  logic [2:0] sppr_i  = 3'd0;
  logic [4:0] len_i   = 5'd0;
  logic       sclk_o, shift_o, sample_o, last_o, busy_o, done_o;

  int total = 0;
  int bad   = 0;

  // Bit order: {sclk, shift, sample, last, busy, done}
  logic [5:0] trace [0:8191];

  spi_sclk_gen dut (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .abort_i  (abort_i),
    .cpol_i   (cpol_i),
    .cpha_i   (cpha_i),
    .spr_i    (spr_i),
    .sppr_i   (sppr_i),
    .len_i    (len_i),
    .sclk_o   (sclk_o),
    .shift_o  (shift_o),
    .sample_o (sample_o),
    .last_o   (last_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [5:0] outs();
    return {sclk_o, shift_o, sample_o, last_o, busy_o, done_o};
  endfunction

  // Expected outputs k cycles after the accepting edge, from the edge timing t0 + e*H.
  function automatic logic [5:0] expect_at(int k, logic cpol, logic cpha, int h, int n);
    int   e;
    int   m;
    logic sc, sh, sa, la, bu, dn;
    m = k / h;
    if (m > 2 * n) m = 2 * n;
    sc = cpol ^ m[0];
    sh = 1'b0;
    sa = 1'b0;
    la = 1'b0;
    bu = (k < (2 * n + 1) * h);
    dn = (k == (2 * n + 1) * h);
    if (k > 0 && (k % h) == 0 && (k / h) <= 2 * n) begin
      e = k / h;
      if (!cpha) begin
        sa = e[0];
        sh = !e[0] && (e < 2 * n);
        la = e[0] && (e == 2 * n - 1);
      end else begin
        sh = e[0];
        sa = !e[0];
        la = (e == 2 * n);
      end
    end
    return {sc, sh, sa, la, bu, dn};
  endfunction

  task automatic set_cfg(input logic cpol, input logic cpha, input logic [2:0] spr,
                         input logic [2:0] sppr, input logic [4:0] len);
    cpol_i = cpol;
    cpha_i = cpha;
    spr_i  = spr;
    sppr_i = sppr;
    len_i  = len;
  endtask

  task automatic capture(input int ncyc, input bit hold, input bit disturb);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    trace[0] = outs();
    if (!hold) start_i = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk_i);
      #1;
      trace[k] = outs();
      if (disturb && k == 10) begin
        cpol_i  = ~cpol_i;
        spr_i   = 3'd7;
        len_i   = 5'd31;
        start_i = 1'b1;
      end
      if (disturb && k == 11) start_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    cpol_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if (outs() !== 6'b000000) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%b want=%b", outs(), 6'b000000);
    end
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;
    total++;
    if (sclk_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_sclk got=%b want=1", sclk_o);
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release_busy got=%b want=0", busy_o);
    end
    cpol_i = 1'b0;
    @(posedge clk_i);
    #1;
    total++;
    if (sclk_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_follows_cpol got=%b want=0", sclk_o);
    end
  endtask

  task automatic test_mode0();
    int ns;
    int nsh;
    set_cfg(1'b0, 1'b0, 3'd0, 3'd0, 5'd7);
    capture(36, 1'b0, 1'b0);
    ns  = 0;
    nsh = 0;
    for (int k = 0; k <= 34; k++) begin
      ns  += int'(trace[k][3]);
      nsh += int'(trace[k][4]);
      total++;
      if (trace[k] !== expect_at(k, 1'b0, 1'b0, 2, 8)) begin
        bad++;
        $display("[TB] FAIL mode0 k=%0d got=%b want=%b", k, trace[k], expect_at(k, 1'b0, 1'b0, 2, 8));
      end
    end
    total++;
    if (ns !== 8) begin
      bad++;
      $display("[TB] FAIL mode0_sample_count got=%0d want=8", ns);
    end
    total++;
    if (nsh !== 7) begin
      bad++;
      $display("[TB] FAIL mode0_shift_count got=%0d want=7", nsh);
    end
    total++;
    if (trace[30] !== 6'b101110) begin
      bad++;
      $display("[TB] FAIL mode0_last_edge got=%b want=101110", trace[30]);
    end
    total++;
    if (trace[34] !== 6'b000001) begin
      bad++;
      $display("[TB] FAIL mode0_done got=%b want=000001", trace[34]);
    end
    total++;
    if (trace[35] !== 6'b000000) begin
      bad++;
      $display("[TB] FAIL mode0_after_done got=%b want=000000", trace[35]);
    end
  endtask

  task automatic test_mode3();
    set_cfg(1'b1, 1'b1, 3'd1, 3'd2, 5'd3);
    @(posedge clk_i);
    #1;
    total++;
    if (sclk_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mode3_idle_sclk got=%b want=1", sclk_o);
    end
    capture(108, 1'b0, 1'b0);
    for (int k = 0; k <= 108; k++) begin
      total++;
      if (trace[k] !== expect_at(k, 1'b1, 1'b1, 12, 4)) begin
        bad++;
        $display("[TB] FAIL mode3 k=%0d got=%b want=%b", k, trace[k], expect_at(k, 1'b1, 1'b1, 12, 4));
      end
    end
    total++;
    if (trace[12] !== 6'b010010) begin
      bad++;
      $display("[TB] FAIL mode3_first_shift got=%b want=010010", trace[12]);
    end
    total++;
    if (trace[96] !== 6'b101110) begin
      bad++;
      $display("[TB] FAIL mode3_last_sample got=%b want=101110", trace[96]);
    end
    total++;
    if (trace[108] !== 6'b100001) begin
      bad++;
      $display("[TB] FAIL mode3_done got=%b want=100001", trace[108]);
    end
  endtask

  task automatic test_max_div();
    set_cfg(1'b0, 1'b0, 3'd7, 3'd7, 5'd0);
    capture(6144, 1'b0, 1'b0);
    for (int k = 0; k <= 6144; k++) begin
      total++;
      if (trace[k] !== expect_at(k, 1'b0, 1'b0, 2048, 1)) begin
        bad++;
        $display("[TB] FAIL maxdiv k=%0d got=%b want=%b", k, trace[k], expect_at(k, 1'b0, 1'b0, 2048, 1));
      end
    end
    total++;
    if (trace[2048] !== 6'b101110) begin
      bad++;
      $display("[TB] FAIL maxdiv_edge1 got=%b want=101110", trace[2048]);
    end
    total++;
    if (trace[6144] !== 6'b000001) begin
      bad++;
      $display("[TB] FAIL maxdiv_done got=%b want=000001", trace[6144]);
    end
  endtask

  task automatic test_disturb();
    set_cfg(1'b0, 1'b0, 3'd1, 3'd0, 5'd3);
    capture(40, 1'b0, 1'b1);
    for (int k = 0; k <= 36; k++) begin
      total++;
      if (trace[k] !== expect_at(k, 1'b0, 1'b0, 4, 4)) begin
        bad++;
        $display("[TB] FAIL disturb k=%0d got=%b want=%b", k, trace[k], expect_at(k, 1'b0, 1'b0, 4, 4));
      end
    end
    for (int k = 37; k <= 40; k++) begin
      total++;
      if (trace[k][1] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL disturb_no_restart k=%0d busy got=%b want=0", k, trace[k][1]);
      end
    end
  endtask

  task automatic test_abort();
    set_cfg(1'b0, 1'b1, 3'd1, 3'd0, 5'd7);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (7) @(posedge clk_i);
    #1;
    total++;
    if ({sclk_o, busy_o} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL abort_before sclk,busy got=%b want=11", {sclk_o, busy_o});
    end
    abort_i = 1'b1;
    @(posedge clk_i);
    #1;
    abort_i = 1'b0;
    total++;
    if (outs() !== 6'b000000) begin
      bad++;
      $display("[TB] FAIL abort_after got=%b want=000000", outs());
    end
    set_cfg(1'b0, 1'b0, 3'd0, 3'd0, 5'd0);
    capture(6, 1'b0, 1'b0);
    for (int k = 0; k <= 6; k++) begin
      total++;
      if (trace[k] !== expect_at(k, 1'b0, 1'b0, 2, 1)) begin
        bad++;
        $display("[TB] FAIL abort_restart k=%0d got=%b want=%b", k, trace[k], expect_at(k, 1'b0, 1'b0, 2, 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    set_cfg(1'b1, 1'b0, 3'd1, 3'd0, 5'd7);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    total++;
    if ({sclk_o, busy_o} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL rstmid_before sclk,busy got=%b want=11", {sclk_o, busy_o});
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (outs() !== 6'b000000) begin
      bad++;
      $display("[TB] FAIL rstmid_async got=%b want=000000", outs());
    end
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;
    total++;
    if ({sclk_o, busy_o} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL rstmid_release sclk,busy got=%b want=10", {sclk_o, busy_o});
    end
    capture(68, 1'b0, 1'b0);
    for (int k = 0; k <= 68; k++) begin
      total++;
      if (trace[k] !== expect_at(k, 1'b1, 1'b0, 4, 8)) begin
        bad++;
        $display("[TB] FAIL rstmid_rerun k=%0d got=%b want=%b", k, trace[k], expect_at(k, 1'b1, 1'b0, 4, 8));
      end
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(1'b0, 1'b1, 3'd0, 3'd0, 5'd1);
    capture(14, 1'b1, 1'b0);
    start_i = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      total++;
      if (trace[k] !== expect_at(k, 1'b0, 1'b1, 2, 2)) begin
        bad++;
        $display("[TB] FAIL b2b k=%0d got=%b want=%b", k, trace[k], expect_at(k, 1'b0, 1'b1, 2, 2));
      end
    end
    total++;
    if (trace[11] !== 6'b000010) begin
      bad++;
      $display("[TB] FAIL b2b_second_accept got=%b want=000010", trace[11]);
    end
    total++;
    if (trace[13] !== 6'b110010) begin
      bad++;
      $display("[TB] FAIL b2b_second_edge1 got=%b want=110010", trace[13]);
    end
    repeat (10) @(posedge clk_i);
    #1;
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_second_end busy got=%b want=0", busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_max_div();
    test_disturb();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
